// File: rtl/energy_window_monitor.sv
// Windowed energy delta sampler with drain FIFO and hysteretic throttle.
// Optional peak tracking: define ENERGY_MON_PEAK_EN.
module energy_window_monitor #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int FIFO_DEPTH    = 4,
  parameter int DELTA_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [63:0]        i_total_energy_pj,
  input  logic [63:0]        i_dynamic_energy_pj,
  input  logic [DELTA_W-1:0] i_budget_pj,
  input  logic [DELTA_W-1:0] i_hyst_pj,
  output logic               o_sample_valid,
  input  logic               i_sample_ready,
  output logic [DELTA_W-1:0] o_sample_total_pj,
  output logic [DELTA_W-1:0] o_sample_dyn_pj,
  output logic               o_overflow,
  output logic [15:0]        o_drop_count,
  output logic               o_throttle_req,
  output logic [31:0]        o_window_count,
  output logic [DELTA_W-1:0] o_peak_window_pj
);

  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, THROT} state_t;

  function automatic logic [DELTA_W-1:0] sat(
    input logic [63:0] v
  );
    if (|v[63:DELTA_W]) return '1;
    return v[DELTA_W-1:0];
  endfunction

  logic               r_armed;
  logic [CW-1:0]      r_wcnt;
  logic [63:0]        r_base_tot;
  logic [63:0]        r_base_dyn;
  logic [AW:0]        r_wp;
  logic [AW:0]        r_rp;
  logic [2*DELTA_W-1:0] r_mem [FIFO_DEPTH];
  logic               r_ovf;
  logic [15:0]        r_drop;
  logic [31:0]        r_wc;
  state_t             r_state;
  state_t             w_state_nx;

  logic               w_close;
  logic [DELTA_W-1:0] w_dtot;
  logic [DELTA_W-1:0] w_ddyn;
  logic [AW:0]        w_used;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [2*DELTA_W-1:0] w_head;

  assign w_close = i_enable && r_armed &&
                   (r_wcnt == CW'(WINDOW_CYCLES - 1));
  assign w_dtot  = sat(i_total_energy_pj - r_base_tot);
  assign w_ddyn  = sat(i_dynamic_energy_pj - r_base_dyn);

  assign w_used  = r_wp - r_rp;
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (w_used == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && i_sample_ready;
  assign w_push  = w_close && (!w_full || w_pop);
  assign w_head  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_armed    <= 1'b0;
      r_wcnt     <= '0;
      r_base_tot <= '0;
      r_base_dyn <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_ovf      <= 1'b0;
      r_drop     <= '0;
      r_wc       <= '0;
    end else begin
      if (!i_enable) begin
        r_armed <= 1'b0;
        r_wcnt  <= '0;
      end else if (!r_armed || w_close) begin
        r_armed    <= 1'b1;
        r_wcnt     <= '0;
        r_base_tot <= i_total_energy_pj;
        r_base_dyn <= i_dynamic_energy_pj;
      end else begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_close) r_wc <= r_wc + 32'd1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_close && !w_push) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
    end
  end

  // Storage is not reset; the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {w_dtot, w_ddyn};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (i_budget_pj == '0) begin
      w_state_nx = IDLE;
    end else if (w_close) begin
      unique case (r_state)
        IDLE:
          if (w_dtot > i_budget_pj) w_state_nx = THROT;
        THROT:
          if (({1'b0, w_dtot} + {1'b0, i_hyst_pj}) <
              {1'b0, i_budget_pj})
            w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

`ifdef ENERGY_MON_PEAK_EN
  logic [DELTA_W-1:0] r_peak;
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_peak <= '0;
    else if (w_close && (w_dtot > r_peak)) r_peak <= w_dtot;
  end
  assign o_peak_window_pj = r_peak;
`else
  assign o_peak_window_pj = '0;
`endif

  assign o_sample_valid    = !w_empty;
  assign o_sample_total_pj = w_empty ? '0 : w_head[2*DELTA_W-1:DELTA_W];
  assign o_sample_dyn_pj   = w_empty ? '0 : w_head[DELTA_W-1:0];
  assign o_overflow        = r_ovf;
  assign o_drop_count      = r_drop;
  assign o_throttle_req    = (r_state == THROT);
  assign o_window_count    = r_wc;

endmodule

// File: tb/tb_energy_window_monitor.sv
// Randomised bench for energy_window_monitor against a queue-based model.
// Peak checks follow ENERGY_MON_PEAK_EN when defined.
module tb_energy_window_monitor;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [63:0]   tot;
  logic [63:0]   dyn;
  logic [DW-1:0] budget;
  logic [DW-1:0] hyst;
  logic          ready;
  logic          s_valid;
  logic [DW-1:0] s_tot;
  logic [DW-1:0] s_dyn;
  logic          ovf;
  logic [15:0]   drop;
  logic          thr;
  logic [31:0]   wc;
  logic [DW-1:0] peak;

  longint unsigned inc_t;
  longint unsigned inc_d;

  int n_tests = 0;
  int n_fail  = 0;

  energy_window_monitor #(
    .WINDOW_CYCLES(W),
    .FIFO_DEPTH(D),
    .DELTA_W(DW)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_enable(en),
    .i_total_energy_pj(tot),
    .i_dynamic_energy_pj(dyn),
    .i_budget_pj(budget),
    .i_hyst_pj(hyst),
    .o_sample_valid(s_valid),
    .i_sample_ready(ready),
    .o_sample_total_pj(s_tot),
    .o_sample_dyn_pj(s_dyn),
    .o_overflow(ovf),
    .o_drop_count(drop),
    .o_throttle_req(thr),
    .o_window_count(wc),
    .o_peak_window_pj(peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: cycles since arm, window closes every W of them.
  bit              m_armed;
  int              m_cnt;
  longint unsigned m_bt, m_bd;
  logic [DW-1:0]   q_t[$];
  logic [DW-1:0]   q_d[$];
  bit              m_ovf;
  int              m_drop;
  bit              m_thr;
  int unsigned     m_wc;
  longint unsigned m_peak;

  function automatic longint unsigned satv(
    input longint unsigned v);
    if (v > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic model_step();
    bit pop, close;
    longint unsigned dt, dd;
    if (!rst_n) begin
      m_armed = 0; m_cnt = 0; m_bt = 0; m_bd = 0;
      q_t.delete(); q_d.delete();
      m_ovf = 0; m_drop = 0; m_thr = 0;
      m_wc = 0; m_peak = 0;
      return;
    end
    pop = (q_t.size() > 0) && ready;
    close = 0;
    if (!en) begin
      m_armed = 0;
    end else if (!m_armed) begin
      m_armed = 1; m_cnt = 0; m_bt = tot; m_bd = dyn;
    end else begin
      m_cnt++;
      close = (m_cnt % W) == 0;
    end
    if (pop) begin
      void'(q_t.pop_front());
      void'(q_d.pop_front());
    end
    if (close) begin
      dt = satv(tot - m_bt);
      dd = satv(dyn - m_bd);
      m_bt = tot; m_bd = dyn;
      m_wc++;
      if (q_t.size() < D) begin
        q_t.push_back(dt[DW-1:0]);
        q_d.push_back(dd[DW-1:0]);
      end else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      if (budget != 0) begin
        if (!m_thr && dt > budget) m_thr = 1;
        else if (m_thr && dt + hyst < budget) m_thr = 0;
      end
`ifdef ENERGY_MON_PEAK_EN
      if (dt > m_peak) m_peak = dt;
`endif
    end
    if (budget == 0) m_thr = 0;
  endtask

  task automatic check_all();
    chk("valid", s_valid, q_t.size() > 0);
    chk("head_tot", s_tot, q_t.size() > 0 ? q_t[0] : 0);
    chk("head_dyn", s_dyn, q_d.size() > 0 ? q_d[0] : 0);
    chk("overflow", ovf, m_ovf);
    chk("drop", drop, m_drop);
    chk("throttle", thr, m_thr);
    chk("wcount", wc, m_wc);
    chk("peak", peak, m_peak);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    tot = tot + inc_t;
    dyn = dyn + inc_d;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ready = 1'b0;
    tot = 0; dyn = 0; inc_t = 0; inc_d = 0;
    budget = 0; hyst = 0;
    cycn(3);
    chk("rst_valid", s_valid, 0);
    chk("rst_wc", wc, 0);
    rst_n = 1'b1;

    // Basic ramp: arm on first enabled cycle.
    tot = 0; dyn = 0; inc_t = 10; inc_d = 4; en = 1'b1;
    cycn(17);
    chk("ramp_tot", s_tot, 160);
    chk("ramp_dyn", s_dyn, 64);
    chk("ramp_wc", wc, 1);

    // Counter wrap around 2^64.
    do_reset();
    tot = 64'hFFFF_FFFF_FFFF_FFCE;
    dyn = 64'hFFFF_FFFF_FFFF_FFF0;
    cycn(17);
    chk("wrap_tot", s_tot, 160);
    chk("wrap_dyn", s_dyn, 64);

    // Six windows with no drain: four held, two dropped.
    cycn(5 * W);
    chk("hold_head", s_tot, 160);
    chk("hold_ovf", ovf, 1);
    chk("hold_drop", drop, 2);
    chk("hold_wc", wc, 6);

    // Full FIFO with ready at close: push and pop together.
    cycn(W - 1);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("full_pp_drop", drop, 2);
    chk("full_pp_valid", s_valid, 1);
    chk("full_pp_wc", wc, 7);

    // Reset mid-window clears everything.
    cycn(5);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_valid", s_valid, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_drop", drop, 0);
    chk("mid_rst_wc", wc, 0);

    // Throttle hysteresis: 160, 85, 50 with budget 100 / hyst 30.
    budget = 100; hyst = 30; ready = 1'b1;
    inc_t = 10;
    cycn(17);
    chk("thr_on", thr, 1);
    inc_t = 5;
    cycn(W);
    chk("thr_hold", thr, 1);
    inc_t = 3;
    cycn(W);
    chk("thr_off", thr, 0);
`ifdef ENERGY_MON_PEAK_EN
    chk("peak_val", peak, 160);
`else
    chk("peak_zero", peak, 0);
`endif

    // Throttle then budget 0 forces release.
    inc_t = 10;
    cycn(W);
    chk("thr_on2", thr, 1);
    budget = 0;
    cyc();
    chk("thr_bud0", thr, 0);

    // Randomised traffic.
    begin
      bit stall;
      stall = 0;
      budget = 150; hyst = 20;
      for (int i = 0; i < 3000; i++) begin
        if (i % 97 == 0) stall = ($urandom_range(0, 2) == 0);
        ready = stall ? ($urandom_range(0, 99) < 3)
                      : ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 199) == 0) en = ~en;
        else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
        rst_n = ($urandom_range(0, 799) != 0);
        if ($urandom_range(0, 63) == 0)
          inc_t = 64'h1_0000_0000;
        else if ($urandom_range(0, 15) == 0)
          inc_t = $urandom_range(0, 20);
        inc_d = $urandom_range(0, 8);
        if (i % 211 == 0) begin
          budget = ($urandom_range(0, 5) == 0) ? 0
                   : $urandom_range(100, 250);
          hyst = $urandom_range(0, 60);
        end
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
